// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: address-register/memory side plus the decode handoff.
// The master is the sequencer; the slave is the memory/decode environment.
interface fetch_sequencer_if #(
  parameter int word_size = 8
);
  logic [word_size-1:0] mem_data;
  logic [word_size-1:0] ar_data;
  logic                 ar_load;
  logic [word_size-1:0] pc_out;
  logic [word_size-1:0] instr_out;
  logic [word_size-1:0] operand_out;
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 branch_en;
  logic [word_size-1:0] branch_addr;
  logic                 halted;

  modport master (
    input  mem_data, instr_ready, branch_en, branch_addr,
    output ar_data, ar_load, pc_out, instr_out, operand_out, instr_valid, halted
  );

  modport slave (
    output mem_data, instr_ready, branch_en, branch_addr,
    input  ar_data, ar_load, pc_out, instr_out, operand_out, instr_valid, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the address register, assembles
// one- or two-word instructions and hands them to decode over valid/ready.
module fetch_sequencer #(
  parameter int                   word_size = 8,
  parameter int                   op_size   = 4,
  parameter logic [word_size-1:0] reset_pc  = '0
) (
  input  logic                clk,
  input  logic                rst,
  fetch_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH1  = 3'd1,
    FETCH2  = 3'd2,
    ADDR1   = 3'd3,
    ADDR2   = 3'd4,
    PRESENT = 3'd5,
    HALT    = 3'd6
  } state_t;

  localparam logic [op_size-1:0] op_rd   = op_size'(4'b0101);
  localparam logic [op_size-1:0] op_wr   = op_size'(4'b0110);
  localparam logic [op_size-1:0] op_br   = op_size'(4'b0111);
  localparam logic [op_size-1:0] op_brz  = op_size'(4'b1000);
  localparam logic [op_size-1:0] op_halt = op_size'(4'b1111);

  state_t               state, state_nxt;
  logic [word_size-1:0] pc, pc_nxt;
  logic [word_size-1:0] instr_q, instr_nxt;
  logic [word_size-1:0] operand_q, operand_nxt;
  logic [word_size-1:0] ar_hold, ar_hold_nxt;
  logic                 issue;

  function automatic logic [op_size-1:0] opcode_of(input logic [word_size-1:0] w);
    return w[word_size-1 -: op_size];
  endfunction

  function automatic logic is_two_word(input logic [word_size-1:0] w);
    logic [op_size-1:0] op;
    op = opcode_of(w);
    return (op == op_rd) || (op == op_wr) || (op == op_br) || (op == op_brz);
  endfunction

  function automatic logic is_halt(input logic [word_size-1:0] w);
    return opcode_of(w) == op_halt;
  endfunction

  // Wraps modulo 2^word_size, so a two-word instruction at the top of memory
  // takes its operand from address zero.
  function automatic logic [word_size-1:0] pc_inc(input logic [word_size-1:0] p);
    return p + word_size'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= reset_pc;
      instr_q   <= '0;
      operand_q <= '0;
      ar_hold   <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      instr_q   <= instr_nxt;
      operand_q <= operand_nxt;
      ar_hold   <= ar_hold_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instr_nxt   = instr_q;
    operand_nxt = operand_q;
    ar_hold_nxt = ar_hold;
    case (state)
      IDLE: state_nxt = FETCH1;
      FETCH1: begin
        ar_hold_nxt = pc;
        pc_nxt      = pc_inc(pc);
        state_nxt   = FETCH2;
      end
      FETCH2: begin
        instr_nxt   = bus.mem_data;
        operand_nxt = '0;
        state_nxt   = is_two_word(bus.mem_data) ? ADDR1 : PRESENT;
      end
      ADDR1: begin
        ar_hold_nxt = pc;
        pc_nxt      = pc_inc(pc);
        state_nxt   = ADDR2;
      end
      ADDR2: begin
        operand_nxt = bus.mem_data;
        state_nxt   = PRESENT;
      end
      PRESENT: begin
        // A handed-off HALT wins over any redirect offered in the same cycle.
        if (bus.instr_ready) begin
          if (is_halt(instr_q)) begin
            state_nxt = HALT;
          end else begin
            if (bus.branch_en) pc_nxt = bus.branch_addr;
            state_nxt = FETCH1;
          end
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs come only from registered state; ar_data holds the last issued address.
  assign issue           = (state == FETCH1) || (state == ADDR1);
  assign bus.ar_load     = issue;
  assign bus.ar_data     = issue ? pc : ar_hold;
  assign bus.pc_out      = pc;
  assign bus.instr_out   = instr_q;
  assign bus.operand_out = operand_q;
  assign bus.instr_valid = (state == PRESENT);
  assign bus.halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory models, address/handoff scoreboards,
// and a second instance started from the top of the address space.
module tb_fetch_sequencer;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.word_size(W)) bus_a ();
  fetch_sequencer_if #(.word_size(W)) bus_b ();

  fetch_sequencer #(.word_size(W), .op_size(4), .reset_pc(8'h00)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  fetch_sequencer #(.word_size(W), .op_size(4), .reset_pc(8'hFF)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  // Read data appears the cycle after the address register is loaded.
  always @(posedge clk) if (bus_a.ar_load) bus_a.mem_data <= mem_a[bus_a.ar_data];
  always @(posedge clk) if (bus_b.ar_load) bus_b.mem_data <= mem_b[bus_b.ar_data];

  logic [7:0]  exp_addr [$];
  logic [15:0] exp_hand [$];
  logic [7:0]  b_addr   [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_a.ar_load) begin
      chk("addr_expected", 32'(exp_addr.size() != 0), 32'd1);
      if (exp_addr.size() != 0) chk("ar_data", 32'(bus_a.ar_data), 32'(exp_addr.pop_front()));
    end
    if (bus_a.instr_valid && bus_a.instr_ready) begin
      chk("hand_expected", 32'(exp_hand.size() != 0), 32'd1);
      if (exp_hand.size() != 0)
        chk("handoff", 32'({bus_a.instr_out, bus_a.operand_out}), 32'(exp_hand.pop_front()));
    end
    if (bus_b.ar_load) b_addr.push_back(bus_b.ar_data);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic hold_reset(input logic rdy);
    rst = 1'b0;
    bus_a.branch_en   = 1'b0;
    bus_a.instr_ready = rdy;
    tick(); tick();
  endtask

  task automatic push_std();
    exp_addr.push_back(8'h00); exp_addr.push_back(8'h01);
    exp_addr.push_back(8'h02); exp_addr.push_back(8'h03);
    exp_hand.push_back(16'h1200); exp_hand.push_back(16'h5080); exp_hand.push_back(16'hF000);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},      32'(bus_a.pc_out),      32'h00);
    chk({tag, "_instr"},   32'(bus_a.instr_out),   32'h00);
    chk({tag, "_operand"}, 32'(bus_a.operand_out), 32'h00);
    chk({tag, "_valid"},   32'(bus_a.instr_valid), 32'd0);
    chk({tag, "_ar_load"}, 32'(bus_a.ar_load),     32'd0);
    chk({tag, "_ar_data"}, 32'(bus_a.ar_data),     32'h00);
    chk({tag, "_halted"},  32'(bus_a.halted),      32'd0);
  endtask

  task automatic wait_halt(input string tag);
    int i = 0;
    while (!bus_a.halted && i < 200) begin tick(); i++; end
    chk({tag, "_halted"}, 32'(bus_a.halted), 32'd1);
    chk({tag, "_pc_end"}, 32'(bus_a.pc_out), 32'h04);
    chk({tag, "_addr_drained"}, 32'(exp_addr.size()), 32'd0);
    chk({tag, "_hand_drained"}, 32'(exp_hand.size()), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int i = 0;
    while (!bus_a.instr_valid && i < 50) begin tick(); i++; end
    chk({tag, "_valid_seen"}, 32'(bus_a.instr_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  i;
    logic last_load;
    logic found;
    for (int k = 0; k < 256; k++) begin mem_a[k] = 8'h00; mem_b[k] = 8'h00; end
    mem_a[0] = 8'h12; mem_a[1] = 8'h50; mem_a[2] = 8'h80; mem_a[3] = 8'hF0;
    mem_b[8'hFF] = 8'h70; mem_b[8'h00] = 8'h20; mem_b[8'h01] = 8'hF0;
    bus_a.instr_ready = 1'b0; bus_a.branch_en = 1'b0; bus_a.branch_addr = 8'h00;
    bus_b.instr_ready = 1'b0; bus_b.branch_en = 1'b0; bus_b.branch_addr = 8'h00;

    // Power-on reset values and a free-running program ending in HALT.
    #1 rst = 1'b0; rst_b = 1'b0;
    #1 chk_reset_vals("por");
    hold_reset(1'b1);
    push_std();
    rst = 1'b1;
    wait_halt("run");
    repeat (10) tick();
    chk("halt_stays", 32'(bus_a.halted), 32'd1);
    chk("halt_no_load", 32'(bus_a.ar_load), 32'd0);
    chk("halt_no_valid", 32'(bus_a.instr_valid), 32'd0);

    // Backpressure at the first PRESENT.
    hold_reset(1'b0);
    exp_addr.push_back(8'h00);
    rst = 1'b1;
    wait_valid("bp");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(bus_a.instr_valid), 32'd1);
      chk("bp_instr", 32'(bus_a.instr_out), 32'h12);
      chk("bp_pc", 32'(bus_a.pc_out), 32'h01);
      chk("bp_ar_load", 32'(bus_a.ar_load), 32'd0);
    end
    exp_addr.push_back(8'h01); exp_addr.push_back(8'h02); exp_addr.push_back(8'h03);
    exp_hand.push_back(16'h1200); exp_hand.push_back(16'h5080); exp_hand.push_back(16'hF000);
    bus_a.instr_ready = 1'b1;
    wait_halt("bp");

    // Branch redirect taken on the handoff of 8'h12.
    hold_reset(1'b0);
    exp_addr.push_back(8'h00);
    rst = 1'b1;
    wait_valid("br");
    exp_hand.push_back(16'h1200);
    exp_addr.push_back(8'h03);
    exp_hand.push_back(16'hF000);
    bus_a.branch_en = 1'b1; bus_a.branch_addr = 8'h03; bus_a.instr_ready = 1'b1;
    tick();
    bus_a.branch_en = 1'b0; bus_a.branch_addr = 8'h00;
    wait_halt("br");

    // Asynchronous reset during ADDR1 of the two-word instruction.
    hold_reset(1'b1);
    exp_addr.push_back(8'h00); exp_addr.push_back(8'h01); exp_addr.push_back(8'h02);
    exp_hand.push_back(16'h1200);
    rst = 1'b1;
    found = 1'b0;
    i = 0;
    while (!found && i < 50) begin
      @(negedge clk);
      if (bus_a.ar_load && bus_a.ar_data == 8'h02) found = 1'b1;
      i++;
    end
    chk("mid_addr1_found", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1 chk_reset_vals("mid");
    tick();
    push_std();
    rst = 1'b1;
    wait_halt("mid");

    // Redirect requests outside PRESENT must be ignored.
    hold_reset(1'b1);
    push_std();
    rst = 1'b1;
    last_load = 1'b0;
    i = 0;
    while (!bus_a.halted && i < 60) begin
      @(posedge clk); #1;
      bus_a.branch_en   = last_load;
      bus_a.branch_addr = 8'hC0;
      last_load = bus_a.ar_load;
      i++;
    end
    bus_a.branch_en = 1'b0;
    wait_halt("ign");

    // Second instance starting at 8'hFF: operand fetched across the wrap.
    rst_b = 1'b1;
    i = 0;
    while (!bus_b.instr_valid && i < 50) begin tick(); i++; end
    chk("wrap_valid", 32'(bus_b.instr_valid), 32'd1);
    chk("wrap_loads", 32'(b_addr.size()), 32'd2);
    if (b_addr.size() == 2) begin
      chk("wrap_addr0", 32'(b_addr[0]), 32'hFF);
      chk("wrap_addr1", 32'(b_addr[1]), 32'h00);
    end
    chk("wrap_instr", 32'(bus_b.instr_out), 32'h70);
    chk("wrap_operand", 32'(bus_b.operand_out), 32'h20);
    chk("wrap_pc", 32'(bus_b.pc_out), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch sequencer for the 8-bit RISC datapath. It sits directly upstream of the address register: it owns the program counter and drives the address register's data input and load strobe, then captures the memory read data. It assembles one-word or two-word instructions and presents them to the decode/execute stage over a valid/ready handshake, accepting branch redirects on handoff.

Parameters:
word_size, 8, width of PC, address and memory data
op_size, 4, opcode field width (MSBs of the instruction word)
reset_pc, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
mem_data  in  word_size  memory read data; valid the cycle after ar_load is asserted
ar_data  out  word_size  address to the address register data input
ar_load  out  1  load strobe to the address register
pc_out  out  word_size  current program counter
instr_out  out  word_size  captured instruction word
operand_out  out  word_size  captured second word; 0 for one-word instructions
instr_valid  out  1  instruction/operand pair available
instr_ready  in  1  downstream accepts the pair
branch_en  in  1  redirect PC; sampled only on the handshake cycle
branch_addr  in  word_size  redirect target
halted  out  1  HALT instruction handed off; fetch stopped

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, pc=reset_pc, instr_out=0, operand_out=0, instr_valid=0, ar_load=0, ar_data=0, halted=0.
- States: IDLE, FETCH1, FETCH2, ADDR1, ADDR2, PRESENT, HALT. State is registered; all outputs are decoded from the state register and datapath registers only.
- IDLE: go to FETCH1 on the next clk.
- FETCH1: ar_data=pc, ar_load=1; pc<=pc+1; go to FETCH2.
- FETCH2: instr_out<=mem_data; operand_out<=0. If opcode (mem_data[word_size-1 -: op_size]) is two-word, go to ADDR1, otherwise go to PRESENT.
- Two-word opcodes: 4'b0101 RD, 4'b0110 WR, 4'b0111 BR, 4'b1000 BRZ. HALT opcode: 4'b1111.
- ADDR1: ar_data=pc, ar_load=1; pc<=pc+1; go to ADDR2.
- ADDR2: operand_out<=mem_data; go to PRESENT.
- PRESENT: instr_valid=1. instr_out and operand_out are held stable while instr_ready=0.
- Handshake in PRESENT (instr_valid & instr_ready):
  - If the opcode is HALT, go to HALT and ignore branch_en.
  - Otherwise, if branch_en=1, pc<=branch_addr; then go to FETCH1.
- branch_en is ignored in all states other than PRESENT.
- HALT: instr_valid=0, ar_load=0, halted=1. The block stays in HALT until reset.
- ar_load is 0 in every state except FETCH1 and ADDR1. ar_data=pc in those states and holds its last value elsewhere.
- PC arithmetic is modulo 2^word_size: 8'hFF+1 -> 8'h00. No overflow flag. A two-word instruction at 8'hFF takes its operand from 8'h00.
- Latency from FETCH1 entry to instr_valid: one-word instruction, 2 cycles (valid in the 3rd state); two-word instruction, 4 cycles.
- Back-to-back throughput with instr_ready tied high: one-word instruction every 3 cycles, two-word every 5 cycles.
- Reset mid-operation: any state returns to IDLE immediately. A partially captured instruction is discarded and instr_valid drops asynchronously.
- A memory value change while not in FETCH2/ADDR2 has no effect.

Test Plan:
- Memory model: mem[0]=8'h12, mem[1]=8'h50, mem[2]=8'h80, mem[3]=8'hF0.
- Reset, then release rst with instr_ready=1 -> ar_load pulses at addresses 00, 01, 02, 03. Handoffs are (12,00), (50,80), (F0,00). Then halted=1, pc_out=04, and no further ar_load.
- Hold instr_ready=0 for 5 cycles at the first PRESENT -> instr_valid stays 1, instr_out stays 12, pc_out stays 01, ar_load stays 0. On ready, fetch resumes at address 01.
- Handshake instr 8'h12 with branch_en=1, branch_addr=8'h03 -> next ar_load address is 03. Then instr F0 is presented and halted=1.
- reset_pc=8'hFF with mem[FF]=8'h70, mem[00]=8'h20 -> two-word handoff (70,20), ar_data sequence FF then 00, pc_out=01 after.
- Assert rst low during ADDR1 of instr 8'h50 -> outputs return to reset values immediately. After release, fetch restarts at address 00.
- branch_en=1 pulsed during FETCH2 and ADDR2 -> ignored; PC sequence is unchanged.
